fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Shares the single write port of a terminal input FIFO between several byte producers (serial receiver, keyboard decoder, internal reply generator, …). Each producer gets a one-entry holding register. A round-robin arbiter drains the holding registers into the FIFO at one word per grant. The block tracks FIFO occupancy, so it never overwrites unread data in a FIFO that has no full flag of its own. It sits between the producers and the FIFO's `in_data`/`in_data_available` inputs, and it watches the FIFO's `out_data_available` pop pulse.

## Interface

Parameters:
- `SOURCES`, 4 — number of producers, 2..8.
- `DATA_WIDTH`, 8 — word width.
- `FIFO_SIZE`, 32 — depth of the downstream FIFO, power of two. Usable capacity is `FIFO_SIZE-1`.

Ports:
- `clk`  in  1 — single clock; all logic on its rising edge.
- `reset`  in  1 — asynchronous, active-high; clears all state immediately.
- `src_data`  in  `SOURCES*DATA_WIDTH` — source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `src_valid`  in  `SOURCES` — one-cycle write strobe per source.
- `src_pending`  out  `SOURCES` — holding register i is occupied.
- `fifo_data`  out  `DATA_WIDTH` — to FIFO `in_data`.
- `fifo_write`  out  1 — to FIFO `in_data_available`; one-cycle pulse.
- `fifo_pop`  in  1 — from FIFO `out_data_available`; one pulse per word removed.
- `fifo_level`  out  `$clog2(FIFO_SIZE)` — words committed to the FIFO and not yet popped.
- `fifo_full`  out  1 — `fifo_level == FIFO_SIZE-1`.
- `overflow`  out  `SOURCES` — sticky per-source data-loss flag.
- `overflow_clear`  in  1 — synchronous clear of all `overflow` bits.

## Operation

- **Capture.** `src_valid[i]` loads the hold register i and sets `pending[i]`.
  - If `pending[i]` is already set and is not being granted this cycle, the new word is dropped, the held word is kept, and `overflow[i]` is set.
  - If `pending[i]` is granted in the same cycle as a new `src_valid[i]`, the new word is loaded, `pending[i]` stays 1, and no overflow is flagged.
- **Grant.** Each cycle, if any pending bit is set and `fifo_level < FIFO_SIZE-1`, exactly one source is selected:
  - The round-robin search starts at `last_grant+1` and wraps modulo `SOURCES`.
  - Registered results: `fifo_data` = hold[sel], `fifo_write` = 1, `pending[sel]` cleared, `last_grant` = sel.
  - Otherwise `fifo_write` = 0 and `fifo_data` holds its last value.
- **Level.** Increments on a grant and decrements on `fifo_pop`. If both occur in the same cycle, the level is unchanged. A `fifo_pop` while the level is 0 is ignored (saturates at 0).
- **Full.** While `fifo_full`, no grants are issued and sources keep their pending words. A `fifo_pop` in the full cycle does not enable a grant in that same cycle; granting resumes on the next cycle.
- **Overflow.** `overflow_clear` has priority over a new overflow event occurring in the same cycle.
- **Reset.** Asynchronous; values take effect immediately.
  - All outputs go to 0: `src_pending`, `fifo_data`, `fifo_write`, `fifo_level`, `fifo_full`, `overflow`.
  - `last_grant` = `SOURCES-1`, so source 0 wins first.
  - A reset mid-operation discards held words. The FIFO must be reset by the same `reset` net so that the level stays consistent.

## Timing

- `src_valid` at edge k → `src_pending` high after edge k.
- The earliest grant is at edge k+1: `fifo_write` is high for the following cycle and the FIFO stores the word at edge k+2.
- Throughput is one word per cycle in aggregate. With all sources continuously pending, each source is granted once per `SOURCES` cycles.
- The `fifo_level` and `fifo_full` update is registered and visible the cycle after the grant or pop edge.
- No combinational path from any input to any output.

## Configuration

- Macro `FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN`.
  - Defined: fixed priority; the lowest-indexed pending source always wins, and `last_grant` is not used.
  - Undefined (default): round-robin as described above.
- Capture, level tracking and overflow logic are identical in both builds.

## Test plan

1. **Single source.** After reset, pulse `src_valid[2]` with 0x41.
   - `src_pending` = 4'b0100 after the edge.
   - Next cycle: `fifo_write` = 1, `fifo_data` = 0x41, `src_pending` = 0, `fifo_level` = 1.
2. **Round-robin fairness.** Keep all 4 sources pending, refilling each one on its grant, with `fifo_pop` every cycle.
   - Grant order is 0,1,2,3,0,1,…
   - With the fixed-priority macro defined, source 0 is granted every cycle and the others starve.
3. **Full.** Fill to 31 words with no pops.
   - `fifo_full` = 1 and the next pending word stays held.
   - One `fifo_pop` → `fifo_level` = 30 and `fifo_full` = 0 on the next cycle; the held word is granted in the following cycle and `fifo_level` returns to 31.
4. **Overflow.** Hold source 1 pending while full, then pulse `src_valid[1]` with 0x55.
   - `overflow[1]` = 1 and the original word is kept.
   - `overflow_clear` → `overflow` = 0; a simultaneous new event still clears.
5. **Grant with refill.** `src_valid[0]` arrives in the same cycle that source 0 is granted.
   - The old word is written, the new word is held with `pending[0]` = 1, and there is no overflow.
6. **Async reset mid-burst.** Assert `reset` between clock edges with 3 words pending and level 10.
   - All outputs are 0 immediately, before the next edge.
   - After release, the first grant goes to source 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: per-source hold registers drained into one FIFO port.
// Optional FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN selects fixed priority.
module fifo_write_arbiter #(
   parameter int SOURCES    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_SIZE  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SOURCES*DATA_WIDTH-1:0] src_data,
   input  logic [SOURCES-1:0]            src_valid,
   output logic [SOURCES-1:0]            src_pending,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic                          fifo_write,
   input  logic                          fifo_pop,
   output logic [$clog2(FIFO_SIZE)-1:0]  fifo_level,
   output logic                          fifo_full,
   output logic [SOURCES-1:0]            overflow,
   input  logic                          overflow_clear
);

   localparam int LW = $clog2(FIFO_SIZE);
   localparam int SW = $clog2(SOURCES);
   localparam logic [LW-1:0] FULL = LW'(FIFO_SIZE - 1);

   logic [DATA_WIDTH-1:0] hold [SOURCES];
   logic [SOURCES-1:0]    pending;
   logic [SOURCES-1:0]    pend_n;
   logic [SOURCES-1:0]    ovf_n;
   logic [SOURCES-1:0]    drop;
   logic [SOURCES-1:0]    load;
   logic [SOURCES-1:0]    gnt_vec;
   logic [LW-1:0]         level;
   logic [LW-1:0]         level_n;
   logic [SW-1:0]         sel;
   logic                  found;
   logic                  grant;
   logic                  pop_ok;

`ifndef FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN
   logic [SW-1:0]         last_grant;

   function automatic logic [SW-1:0] rr_idx(
      input logic [SW-1:0] base,
      input int            k
   );
      int t;
      t = (int'(base) + k) % SOURCES;
      return SW'(t);
   endfunction
`endif

   // pick one pending source; search order depends on build
   always_comb begin
      sel   = '0;
      found = 1'b0;
`ifdef FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN
      for (int k = 0; k < SOURCES; k++) begin
         if (!found && pending[k]) begin
            found = 1'b1;
            sel   = SW'(k);
         end
      end
`else
      for (int k = 1; k <= SOURCES; k++) begin
         if (!found && pending[rr_idx(last_grant, k)]) begin
            found = 1'b1;
            sel   = rr_idx(last_grant, k);
         end
      end
`endif
   end

   // grant only when room; a pop this cycle does not free room yet
   always_comb begin
      grant  = found && (level != FULL);
      pop_ok = fifo_pop && (level != '0);
      level_n = level;
      if (grant && !pop_ok) begin
         level_n = level + 1'b1;
      end else if (!grant && pop_ok) begin
         level_n = level - 1'b1;
      end
   end

   // capture, drop-on-busy and overflow next-state per source
   always_comb begin
      pend_n  = pending;
      drop    = '0;
      load    = '0;
      gnt_vec = '0;
      for (int i = 0; i < SOURCES; i++) begin
         gnt_vec[i] = grant && (sel == SW'(i));
         if (src_valid[i] && pending[i] && !gnt_vec[i]) begin
            drop[i] = 1'b1;
         end else if (src_valid[i]) begin
            load[i]   = 1'b1;
            pend_n[i] = 1'b1;
         end else if (gnt_vec[i]) begin
            pend_n[i] = 1'b0;
         end
      end
      ovf_n = overflow_clear ? '0 : (overflow | drop);
   end

   // hold registers load on accepted strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SOURCES; i++) begin
            hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SOURCES; i++) begin
            if (load[i]) begin
               hold[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // registered write port, occupancy and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending    <= '0;
         overflow   <= '0;
         fifo_data  <= '0;
         fifo_write <= 1'b0;
         level      <= '0;
         fifo_full  <= 1'b0;
      end else begin
         pending    <= pend_n;
         overflow   <= ovf_n;
         fifo_write <= grant;
         level      <= level_n;
         fifo_full  <= (level_n == FULL);
         if (grant) begin
            fifo_data <= hold[sel];
         end
      end
   end

`ifndef FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN
   // round-robin pointer; reset value makes source 0 win first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= SW'(SOURCES - 1);
      end else if (grant) begin
         last_grant <= sel;
      end
   end
`endif

   assign src_pending = pending;
   assign fifo_level  = level;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed vectors for fifo_write_arbiter.
// Expected values are hand-derived; fixed-priority build handled by ifdef.
module tb_fifo_write_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] src_data;
   logic [3:0]  src_valid;
   logic [3:0]  src_pending;
   logic [7:0]  fifo_data;
   logic        fifo_write;
   logic        fifo_pop;
   logic [4:0]  fifo_level;
   logic        fifo_full;
   logic [3:0]  overflow;
   logic        overflow_clear;

   int total;
   int bad;
   logic [7:0] held [4];

   fifo_write_arbiter #(
      .SOURCES(4),
      .DATA_WIDTH(8),
      .FIFO_SIZE(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .src_data(src_data),
      .src_valid(src_valid),
      .src_pending(src_pending),
      .fifo_data(fifo_data),
      .fifo_write(fifo_write),
      .fifo_pop(fifo_pop),
      .fifo_level(fifo_level),
      .fifo_full(fifo_full),
      .overflow(overflow),
      .overflow_clear(overflow_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [7:0] d);
      src_data[i*8 +: 8] = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int s;
      int sidx;
      total          = 0;
      bad            = 0;
      reset          = 1'b1;
      src_data       = '0;
      src_valid      = '0;
      fifo_pop       = 1'b0;
      overflow_clear = 1'b0;
      #3;
      check("rst_pend", 32'(src_pending), 0);
      check("rst_wr", 32'(fifo_write), 0);
      check("rst_lvl", 32'(fifo_level), 0);
      check("rst_full", 32'(fifo_full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_data", 32'(fifo_data), 0);
      tick();
      reset = 1'b0;
      tick();

      // single source
      set_src(2, 8'h41);
      src_valid = 4'b0100;
      tick();
      src_valid = '0;
      check("t1_pend", 32'(src_pending), 32'h4);
      check("t1_wr0", 32'(fifo_write), 0);
      tick();
      check("t1_wr", 32'(fifo_write), 1);
      check("t1_data", 32'(fifo_data), 32'h41);
      check("t1_pend2", 32'(src_pending), 0);
      check("t1_lvl", 32'(fifo_level), 1);
      tick();
      check("t1_idle", 32'(fifo_write), 0);
      check("t1_hold", 32'(fifo_data), 32'h41);

      // fairness with refill on grant, pop every cycle
      do_reset();
      for (int i = 0; i < 4; i++) begin
         held[i] = 8'(8'h10 + i);
         set_src(i, held[i]);
      end
      src_valid = 4'hF;
      tick();
      fifo_pop = 1'b1;
      for (int n = 0; n < 8; n++) begin
`ifdef FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN
         s = 0;
`else
         s = n % 4;
`endif
         src_valid = 4'(1 << s);
         set_src(s, 8'(8'h30 + n));
         tick();
         check("t2_wr", 32'(fifo_write), 1);
         check("t2_data", 32'(fifo_data), 32'(held[s]));
         check("t2_pend", 32'(src_pending), 32'hF);
         check("t2_lvl", 32'(fifo_level), 1);
         check("t2_ovf", 32'(overflow), 0);
         held[s] = 8'(8'h30 + n);
      end
      src_valid = '0;
      fifo_pop  = 1'b0;

      // fill to full from source 0, refilling every grant
      do_reset();
      for (int n = 0; n < 32; n++) begin
         set_src(0, 8'(n));
         src_valid = 4'b0001;
         tick();
      end
      src_valid = '0;
      check("t3_lvl", 32'(fifo_level), 31);
      check("t3_full", 32'(fifo_full), 1);
      check("t3_pend", 32'(src_pending), 1);
      check("t3_last", 32'(fifo_data), 30);
      set_src(1, 8'h66);
      src_valid = 4'b0010;
      tick();
      src_valid = '0;
      check("t3_nowr", 32'(fifo_write), 0);
      check("t3_pend2", 32'(src_pending), 32'h3);
      check("t3_lvl2", 32'(fifo_level), 31);

      // overflow while full keeps the original word
      set_src(1, 8'h55);
      src_valid = 4'b0010;
      tick();
      src_valid = '0;
      check("t4_ovf", 32'(overflow), 32'h2);
      check("t4_pend", 32'(src_pending), 32'h3);
      fifo_pop = 1'b1;
      tick();
      fifo_pop = 1'b0;
      check("t3_popwr", 32'(fifo_write), 0);
      check("t3_poplvl", 32'(fifo_level), 30);
      check("t3_popfull", 32'(fifo_full), 0);
      tick();
      check("t3_rswr", 32'(fifo_write), 1);
      check("t3_rslvl", 32'(fifo_level), 31);
      check("t3_rsfull", 32'(fifo_full), 1);
`ifdef FIFO_WRITE_ARBITER_FIXED_PRIORITY_EN
      check("t3_rsdata", 32'(fifo_data), 32'h1F);
      check("t3_rspend", 32'(src_pending), 32'h2);
      sidx = 1;
`else
      check("t4_kept", 32'(fifo_data), 32'h66);
      check("t3_rspend", 32'(src_pending), 32'h1);
      sidx = 0;
`endif
      check("t4_ovf2", 32'(overflow), 32'h2);
      src_valid      = 4'(1 << sidx);
      overflow_clear = 1'b1;
      tick();
      check("t4_clrpri", 32'(overflow), 0);
      overflow_clear = 1'b0;
      tick();
      src_valid = '0;
      check("t4_ovf3", 32'(overflow), 32'(1 << sidx));
      overflow_clear = 1'b1;
      tick();
      overflow_clear = 1'b0;
      check("t4_clr", 32'(overflow), 0);

      // grant with same-cycle refill
      do_reset();
      set_src(0, 8'hA1);
      src_valid = 4'b0001;
      tick();
      set_src(0, 8'hA2);
      tick();
      src_valid = '0;
      check("t5_wr", 32'(fifo_write), 1);
      check("t5_data", 32'(fifo_data), 32'hA1);
      check("t5_pend", 32'(src_pending), 1);
      check("t5_ovf", 32'(overflow), 0);
      tick();
      check("t5_data2", 32'(fifo_data), 32'hA2);
      check("t5_pend2", 32'(src_pending), 0);

      // async reset mid-burst
      do_reset();
      for (int n = 0; n <= 10; n++) begin
         set_src(0, 8'(n));
         src_valid = 4'b0001;
         if (n == 10) begin
            set_src(1, 8'hB1);
            set_src(2, 8'hB2);
            src_valid = 4'b0111;
         end
         tick();
      end
      src_valid = '0;
      check("t6_lvl", 32'(fifo_level), 10);
      check("t6_pend", 32'(src_pending), 32'h7);
      check("t6_wr", 32'(fifo_write), 1);
      #3;
      reset = 1'b1;
      #1;
      check("t6_rpend", 32'(src_pending), 0);
      check("t6_rwr", 32'(fifo_write), 0);
      check("t6_rdata", 32'(fifo_data), 0);
      check("t6_rlvl", 32'(fifo_level), 0);
      check("t6_rfull", 32'(fifo_full), 0);
      check("t6_rovf", 32'(overflow), 0);
      #1;
      reset = 1'b0;
      set_src(0, 8'hC0);
      set_src(1, 8'hC1);
      set_src(3, 8'hC3);
      src_valid = 4'b1011;
      tick();
      src_valid = '0;
      check("t6_pend2", 32'(src_pending), 32'hB);
      tick();
      check("t6_g0", 32'(fifo_data), 32'hC0);
      tick();
      check("t6_g1", 32'(fifo_data), 32'hC1);
      tick();
      check("t6_g3", 32'(fifo_data), 32'hC3);
      check("t6_lvl2", 32'(fifo_level), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
